// File: rtl/reg_file_mp.sv
// reg_file_mp: NUM_RD-read/1-write register file with hardwired-zero entry and sequential clear engine.
// Define REGFILE_BYPASS_EN to forward a committing write to matching read ports in the same cycle.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       clr_req_i,
  output logic                       busy_o,
  output logic                       clr_done_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q, clr_done_q, wr_ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_fire, zero_hit;
  assign wr_fire    = wr_en_i && wr_ready_q;
  assign zero_hit   = (ZERO_REG != 0) && (wr_addr_i == '0);
  assign wr_ready_o = wr_ready_q;
  assign busy_o     = busy_q;
  assign clr_done_o = clr_done_q;
  // Write port and clear engine never overlap: wr_ready is low throughout CLEAR.
  always_comb begin
    mem_d = mem_q;
    if (wr_fire && !zero_hit) mem_d[wr_addr_i] = wr_data_i;
    if (state_q == CLEAR) mem_d[idx_q] = '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (clr_req_i) begin
          state_q    <= CLEAR;
          idx_q      <= FIRST;
          busy_q     <= 1'b1;
          wr_ready_q <= 1'b0;
        end
        CLEAR: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_q == LAST) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
            wr_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr_i[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rd_data_o[i*DATA_W +: DATA_W] = !rst_ni ? '0 :
      (wr_fire && !zero_hit && wr_addr_i == ra) ? wr_data_i : mem_q[ra];
`else
    assign rd_data_o[i*DATA_W +: DATA_W] = !rst_ni ? '0 : mem_q[ra];
`endif
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized self-checking bench for reg_file_mp against an array reference model.
module tb_reg_file_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic wr_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, busy, clr_done;
  logic [DW-1:0] model [DEPTH];
  int n_checks = 0, n_fail = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .clr_req_i(clr_req), .busy_o(busy), .clr_done_o(clr_done));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return (a == 0) ? '0 : model[a];
  endfunction

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    set_rd(1, 3);
    n_checks++; if (port(0) !== '0 || port(1) !== '0) begin n_fail++; $display("FAIL reset_rd got %h/%h want 0/0", port(0), port(1)); end
    @(negedge clk); rst_n = 1'b1;
    tick;
    n_checks++; if (wr_ready !== 1'b1 || busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got rdy=%b busy=%b done=%b want 1/0/0", wr_ready, busy, clr_done); end
    for (int k = 0; k < DEPTH; k++) begin
      set_rd(k, DEPTH - 1 - k);
      n_checks++; if (port(0) !== '0 || port(1) !== '0) begin n_fail++; $display("FAIL reset_entry%0d got %h/%h want 0", k, port(0), port(1)); end
    end
  endtask

  task automatic test_write_read;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick;
    model[5] = 32'hDEADBEEF;
    wr_en = 1'b0;
    set_rd(0, 5);
    n_checks++; if (port(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x5 got %h want deadbeef", port(1)); end
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    tick;
    wr_en = 1'b0;
    set_rd(0, 5);
    n_checks++; if (port(0) !== '0) begin n_fail++; $display("FAIL wr_x0 got %h want 0", port(0)); end
  endtask

  task automatic test_bypass;
    logic [DW-1:0] exp;
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    set_rd(7, 5);
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = ref_rd(7);
`endif
    n_checks++; if (port(0) !== exp) begin n_fail++; $display("FAIL bypass_same got %h want %h", port(0), exp); end
    tick;
    model[7] = 32'hA5A5A5A5;
    wr_en = 1'b0;
    set_rd(7, 5);
    n_checks++; if (port(0) !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_after got %h want a5a5a5a5", port(0)); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      int a0, a1, wa;
      logic we;
      logic [DW-1:0] wd, e0, e1;
      we = 1'($urandom_range(0, 1)); wa = $urandom_range(0, DEPTH - 1); wd = $urandom;
      a0 = $urandom_range(0, DEPTH - 1); a1 = (n % 4 == 0) ? wa : $urandom_range(0, DEPTH - 1);
      wr_en = we; wr_addr = AW'(wa); wr_data = wd;
      set_rd(a0, a1);
      e0 = ref_rd(a0); e1 = ref_rd(a1);
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && wa == a0) e0 = wd;
      if (we && wa != 0 && wa == a1) e1 = wd;
`endif
      n_checks++; if (port(0) !== e0 || port(1) !== e1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d got %h/%h rdy=%b want %h/%h rdy=1", n, port(0), port(1), wr_ready, e0, e1); end
      tick;
      if (we && wa != 0) model[wa] = wd;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_clear;
    for (int k = 1; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = 32'h11111111;
      tick;
      model[k] = 32'h11111111;
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int c = 0; c < DEPTH - 1; c++) begin
      set_rd(c + 1, c);
      n_checks++; if (busy !== 1'b1 || wr_ready !== 1'b0 || clr_done !== 1'b0 || port(0) !== ref_rd(c + 1) || port(1) !== ref_rd(c)) begin
        n_fail++; $display("FAIL clear_cyc%0d got busy=%b rdy=%b done=%b rd=%h/%h want 1/0/0 %h/%h", c, busy, wr_ready, clr_done, port(0), port(1), ref_rd(c + 1), ref_rd(c));
      end
      tick;
      model[c + 1] = '0;
    end
    n_checks++; if (busy !== 1'b0 || clr_done !== 1'b1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL clear_done got busy=%b done=%b rdy=%b want 0/1/1", busy, clr_done, wr_ready); end
    tick;
    n_checks++; if (clr_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_pulse got done=%b busy=%b want 0/0", clr_done, busy); end
    for (int k = 0; k < DEPTH; k++) begin
      set_rd(k, k);
      n_checks++; if (port(0) !== '0) begin n_fail++; $display("FAIL clear_entry%0d got %h want 0", k, port(0)); end
    end
  endtask

  task automatic test_write_stall;
    int waited;
    bit ok;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'hCAFEF00D;
    set_rd(9, 9);
    waited = 0; ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (wr_ready === 1'b1) begin ok = 1; break; end
      n_checks++; if (port(0) !== '0) begin n_fail++; $display("FAIL stall_cyc%0d x9 got %h want 0", c, port(0)); end
      tick;
      waited++;
    end
    n_checks++; if (!ok || waited != DEPTH - 1 || clr_done !== 1'b1) begin n_fail++; $display("FAIL stall_wait got %0d cycles done=%b want %0d done=1", waited, clr_done, DEPTH - 1); end
    tick;
    wr_en = 1'b0;
    for (int k = 1; k < DEPTH; k++) model[k] = '0;
    model[9] = 32'hCAFEF00D;
    set_rd(9, 8);
    n_checks++; if (port(0) !== 32'hCAFEF00D || port(1) !== '0) begin n_fail++; $display("FAIL stall_commit got %h/%h want cafef00d/0", port(0), port(1)); end
  endtask

  task automatic test_reset_mid_clear;
    int busy_cnt, done_cnt;
    for (int k = 1; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = $urandom | 32'h1;
      tick;
      model[k] = wr_data;
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (10) tick;
    set_rd(20, 25);
    n_checks++; if (busy !== 1'b1 || port(0) !== model[20]) begin n_fail++; $display("FAIL midclr_pre got busy=%b x20=%h want 1/%h", busy, port(0), model[20]); end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    n_checks++; if (busy !== 1'b0 || clr_done !== 1'b0 || port(0) !== '0 || port(1) !== '0) begin n_fail++; $display("FAIL midclr_rst got busy=%b done=%b rd=%h/%h want 0/0 0/0", busy, clr_done, port(0), port(1)); end
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    repeat (3) begin tick; if (clr_done !== 1'b0) done_cnt++; end
    n_checks++; if (done_cnt != 0 || busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL midclr_after got done_cnt=%0d busy=%b rdy=%b want 0/0/1", done_cnt, busy, wr_ready); end
    for (int k = 0; k < DEPTH; k++) begin
      set_rd(k, k);
      n_checks++; if (port(1) !== '0) begin n_fail++; $display("FAIL midclr_entry%0d got %h want 0", k, port(1)); end
    end
    for (int k = 1; k <= 2; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = 32'h0BAD0000 + k;
      tick;
      model[k] = wr_data;
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    set_rd(1, 2);
    n_checks++; if (port(0) !== model[1] || port(1) !== model[2]) begin n_fail++; $display("FAIL restart_c0 got %h/%h want %h/%h", port(0), port(1), model[1], model[2]); end
    tick;
    model[1] = '0;
    n_checks++; if (port(0) !== '0 || port(1) !== model[2]) begin n_fail++; $display("FAIL restart_c1 got %h/%h want 0/%h", port(0), port(1), model[2]); end
    busy_cnt = 1; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      tick;
    end
    n_checks++; if (busy_cnt != DEPTH - 1 || done_cnt != 1) begin n_fail++; $display("FAIL restart_len got busy=%0d done=%0d want %0d/1", busy_cnt, done_cnt, DEPTH - 1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_random;
    test_clear;
    test_write_stall;
    test_reset_mid_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
